// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in parallel-out deserializer.
// The state enum doubles as the 1-bit encoding constants ST_IDLE / ST_RECV.
package sipo_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  // Wide enough to hold 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shifter.sv
// Shift register and bit counter for sipo_deser.
// o_word is the word including the bit being captured this cycle, so the top can latch it on the completing edge.
module sipo_shifter
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_capture,
  input  logic             i_restart,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_word,
  output logic             o_done,
  output logic             o_busy
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_shift;
  logic [CW-1:0]    w_count_inc;

  // After WIDTH shifts the first bit ends up at [0] (LSB first) or [WIDTH-1] (MSB first).
  always_comb begin
    w_base      = i_restart ? '0 : r_sreg;
    w_count_inc = (i_restart ? '0 : r_count) + CW'(1);
    if (LSB_FIRST) w_shift = {i_bit, w_base[WIDTH-1:1]};
    else           w_shift = {w_base[WIDTH-2:0], i_bit};
  end

  assign o_word = w_shift;
  assign o_done = i_capture && (w_count_inc == LAST);
  assign o_busy = (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sreg  <= '0;
      r_count <= '0;
    end else if (i_capture) begin
      if (o_done) begin
        r_sreg  <= '0;
        r_count <= '0;
      end else begin
        r_sreg  <= w_shift;
        r_count <= w_count_inc;
      end
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer: framing FSM, one-word holding register and overrun flag.
// Words land in the holding register on the same edge that samples their final bit.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_si,
  input  logic             i_si_valid,
  input  logic             i_si_start,
  output logic [WIDTH-1:0] o_pdata,
  output logic             o_pvalid,
  input  logic             i_pready,
  output logic             o_busy,
  output logic             o_overrun
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_capture;
  logic             w_restart;
  logic [WIDTH-1:0] w_word;
  logic             w_done;
  logic             w_partial;
  logic [WIDTH-1:0] r_pdata;
  logic             r_pvalid;
  logic             r_overrun;

  // IDLE ignores unframed bits; in RECV every valid bit is taken.
  assign w_capture = i_si_valid && ((r_state == ST_RECV) || i_si_start);
  assign w_restart = i_si_valid && i_si_start;

  sipo_shifter #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shifter (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_capture (w_capture),
    .i_restart (w_restart),
    .i_bit     (i_si),
    .o_word    (w_word),
    .o_done    (w_done),
    .o_busy    (w_partial)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_si_valid && i_si_start) w_state_nxt = ST_RECV;
      ST_RECV: w_state_nxt = ST_RECV;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A completing word is dropped only when the held word is neither empty nor being consumed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pdata   <= '0;
      r_pvalid  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_done) begin
        if (!r_pvalid || i_pready) begin
          r_pdata  <= w_word;
          r_pvalid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_pvalid && i_pready) begin
        r_pvalid <= 1'b0;
      end
    end
  end

  assign o_pdata   = r_pdata;
  assign o_pvalid  = r_pvalid;
  assign o_overrun = r_overrun;
  assign o_busy    = (r_state == ST_RECV) && w_partial;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: an LSB-first and an MSB-first instance share the serial inputs.
module tb_sipo_deser;

  logic       clk;
  logic       rst;
  logic       si;
  logic       si_valid;
  logic       si_start;
  logic       pready;
  logic [3:0] pdata_l, pdata_m;
  logic       pvalid_l, pvalid_m;
  logic       busy_l, busy_m;
  logic       ovr_l, ovr_m;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] piso_d;

  sipo_deser #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb (
    .i_clk(clk), .i_rst(rst), .i_si(si), .i_si_valid(si_valid), .i_si_start(si_start),
    .o_pdata(pdata_l), .o_pvalid(pvalid_l), .i_pready(pready), .o_busy(busy_l), .o_overrun(ovr_l)
  );

  sipo_deser #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (
    .i_clk(clk), .i_rst(rst), .i_si(si), .i_si_valid(si_valid), .i_si_start(si_start),
    .o_pdata(pdata_m), .o_pvalid(pvalid_m), .i_pready(pready), .o_busy(busy_m), .o_overrun(ovr_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one bit across one rising edge; outputs are sampled 1 time unit after it.
  task automatic send_bit(input logic b, input logic start);
    @(negedge clk);
    si       = b;
    si_valid = 1'b1;
    si_start = start;
    @(posedge clk);
    #1;
    si_valid = 1'b0;
    si_start = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    si_valid = 1'b0;
    si_start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; si = 1'b0; si_valid = 1'b0; si_start = 1'b0; pready = 1'b0;
    // stray bits during reset must be ignored
    @(negedge clk); si_valid = 1'b1; si_start = 1'b1; si = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_pdata",   pdata_l,  4'h0);
    chk("rst_pvalid",  pvalid_l, 1'b0);
    chk("rst_busy",    busy_l,   1'b0);
    chk("rst_overrun", ovr_l,    1'b0);
    @(negedge clk); rst = 1'b0; si_valid = 1'b0; si_start = 1'b0; pready = 1'b1;

    // idle ignores unframed bits
    send_bit(1'b1, 1'b0);
    chk("idle_ignore_busy", busy_l, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    chk("idle_ignore_pvalid", pvalid_l, 1'b0);

    // basic LSB-first frame 1,1,0,1 -> B (MSB instance -> D)
    send_bit(1'b1, 1'b1); chk("basic_busy1", busy_l, 1'b1);
    send_bit(1'b1, 1'b0); chk("basic_busy2", busy_l, 1'b1);
    send_bit(1'b0, 1'b0); chk("basic_busy3", busy_l, 1'b1);
    chk("basic_pvalid_early", pvalid_l, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("basic_pdata",  pdata_l,  4'hB);
    chk("basic_pvalid", pvalid_l, 1'b1);
    chk("basic_busy4",  busy_l,   1'b0);
    chk("basic_msb_pdata", pdata_m, 4'hD);
    idle_cycle();
    chk("basic_consumed", pvalid_l, 1'b0);
    chk("basic_hold",     pdata_l,  4'hB);

    // loopback from a 4-bit LSB-first PISO loaded with 0110
    piso_d = 4'b0110;
    for (int i = 0; i < 4; i++) send_bit(piso_d[i], i == 0);
    chk("loop_pdata",  pdata_l,  4'h6);
    chk("loop_pvalid", pvalid_l, 1'b1);
    idle_cycle();

    // MSB-first frame 1,0,0,0 -> 8 (LSB instance -> 1)
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    chk("msb_pdata",  pdata_m,  4'h8);
    chk("msb_pvalid", pvalid_m, 1'b1);
    chk("msb_lsbinst_pdata", pdata_l, 4'h1);
    idle_cycle();

    // backpressure: 3 then 5 back-to-back with pready low
    pready = 1'b0;
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    chk("bp_first_pdata",   pdata_l,  4'h3);
    chk("bp_first_pvalid",  pvalid_l, 1'b1);
    chk("bp_first_overrun", ovr_l,    1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    chk("bp_no_early_ovr", ovr_l, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("bp_overrun",     ovr_l,    1'b1);
    chk("bp_pdata_kept",  pdata_l,  4'h3);
    chk("bp_pvalid_kept", pvalid_l, 1'b1);
    chk("bp_busy",        busy_l,   1'b0);
    idle_cycle();
    chk("bp_overrun_pulse", ovr_l,   1'b0);
    chk("bp_pdata_stable",  pdata_l, 4'h3);
    pready = 1'b1;
    idle_cycle();
    chk("bp_drain_pvalid", pvalid_l, 1'b0);
    chk("bp_drain_pdata",  pdata_l,  4'h3);

    // simultaneous consume and complete: hold A, complete C with pready rising on the last bit
    pready = 1'b0;
    send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    chk("sim_held_pdata", pdata_l, 4'hA);
    send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    pready = 1'b1;
    send_bit(1'b1, 1'b0);
    chk("sim_pdata",   pdata_l,  4'hC);
    chk("sim_pvalid",  pvalid_l, 1'b1);
    chk("sim_overrun", ovr_l,    1'b0);
    idle_cycle();
    chk("sim_consumed", pvalid_l, 1'b0);

    // re-alignment: 1,1 then restart with 0,0,1,0 -> 4
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    chk("realign_busy", busy_l, 1'b1);
    chk("realign_no_word", pvalid_l, 1'b0);
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    chk("realign_pdata",  pdata_l,  4'h4);
    chk("realign_pvalid", pvalid_l, 1'b1);

    // reset mid-word with a word held
    pready = 1'b0;
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0);
    chk("midrst_busy_before", busy_l, 1'b1);
    @(negedge clk); rst = 1'b1; si = 1'b1; si_valid = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy",   busy_l,   1'b0);
    chk("midrst_pvalid", pvalid_l, 1'b0);
    chk("midrst_pdata",  pdata_l,  4'h0);
    @(negedge clk); rst = 1'b0; si_valid = 1'b0;
    pready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1, 1'b0);
      chk("postrst_busy", busy_l, 1'b0);
    end
    chk("postrst_pvalid", pvalid_l, 1'b0);
    chk("postrst_pdata",  pdata_l,  4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
